// File: rtl/gol_pkg.sv
// gol_pkg: shared board geometry, controller state encoding and row addressing helper
package gol_pkg;
  localparam int BOARD_COLS  = 16;
  localparam int BOARD_ROWS  = 16;
  localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, EVAL, COMMIT} ctrl_state_t;

  function automatic logic [7:0] row_base(input logic [3:0] row);
    return {row, 4'b0000};
  endfunction
endpackage

// File: rtl/gol_tick_divider.sv
// gol_tick_divider: free-running divider that pulses tick on count TICK_DIV-1 while enabled
module gol_tick_divider #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (!reset || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/gol_gen_controller.sv
// gol_gen_controller: sequences the Life engine (run/pause/step/clear, host row writes); GOL_STABLE_HALT_EN adds still-life/extinction auto-stop
module gol_gen_controller
  import gol_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int TICK_DIV    = 25000000,
  parameter int ALG_LATENCY = 1,
  parameter int GEN_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_run,
  input  logic                       cmd_pause,
  input  logic                       cmd_step,
  input  logic                       cmd_clear,
  input  logic                       wr_en,
  input  logic [3:0]                 wr_row,
  input  logic [15:0]                wr_data,
  output logic                       wr_ready,
  output logic [ROWS*BOARD_COLS-1:0] alg_board_in,
  input  logic [ROWS*BOARD_COLS-1:0] alg_board_out,
  output logic [ROWS*BOARD_COLS-1:0] board,
  output logic [GEN_W-1:0]           generation,
  output logic                       running,
  output logic                       busy,
  output logic                       halted
);
  localparam int LW = ALG_LATENCY > 1 ? $clog2(ALG_LATENCY) : 1;
  ctrl_state_t state;
  logic [LW-1:0] lat_cnt;
  logic pause_pending, tick, stop;

  assign alg_board_in = board;
  assign wr_ready     = state == IDLE;
  assign busy         = state == EVAL || state == COMMIT;

  gol_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state == WAIT_TICK),
    .clr   (state != WAIT_TICK),
    .tick  (tick)
  );

`ifdef GOL_STABLE_HALT_EN
  assign stop = alg_board_out == board || alg_board_out == '0;
`else
  assign stop    = 1'b0;
  assign halted  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      board         <= '0;
      generation    <= '0;
      running       <= 1'b0;
      pause_pending <= 1'b0;
      lat_cnt       <= '0;
`ifdef GOL_STABLE_HALT_EN
      halted        <= 1'b0;
`endif
    end else begin
`ifdef GOL_STABLE_HALT_EN
      if (cmd_run || cmd_step || cmd_clear || (wr_en && wr_ready)) halted <= 1'b0;
`endif
      if (cmd_clear) begin
        state         <= IDLE;
        board         <= '0;
        generation    <= '0;
        running       <= 1'b0;
        pause_pending <= 1'b0;
        lat_cnt       <= '0;
      end else begin
        case (state)
          IDLE: begin
            lat_cnt <= '0;
            if (wr_en) board[row_base(wr_row) +: BOARD_COLS] <= wr_data;
            if (!cmd_pause && cmd_run) begin
              running <= 1'b1;
              state   <= WAIT_TICK;
            end else if (!cmd_pause && cmd_step) state <= EVAL;
          end
          WAIT_TICK: begin
            if (cmd_pause) begin
              running <= 1'b0;
              state   <= IDLE;
            end else if (tick) state <= EVAL;
          end
          EVAL: begin
            if (cmd_pause) pause_pending <= 1'b1;
            lat_cnt <= lat_cnt == LW'(ALG_LATENCY - 1) ? '0 : lat_cnt + 1'b1;
            if (lat_cnt == LW'(ALG_LATENCY - 1)) state <= COMMIT;
          end
          COMMIT: begin
            board      <= alg_board_out;
            generation <= generation == '1 ? generation : generation + 1'b1;
            if (running && !pause_pending && !cmd_pause && !stop) state <= WAIT_TICK;
            else begin
              state         <= IDLE;
              running       <= 1'b0;
              pause_pending <= 1'b0;
            end
`ifdef GOL_STABLE_HALT_EN
            if (stop) halted <= 1'b1;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gol_gen_controller.sv
// tb_gol_gen_controller: directed checks of the generation controller against a 1-cycle Life engine model
module tb_gol_gen_controller;
  logic clk = 0, reset = 0;
  logic cmd_run = 0, cmd_pause = 0, cmd_step = 0, cmd_clear = 0, wr_en = 0;
  logic [3:0] wr_row = 0;
  logic [15:0] wr_data = 0;
  logic wr_ready, running, busy, halted;
  logic [255:0] alg_in, alg_out = '0, board, exp_b;
  logic [15:0] generation;
  int checks = 0, errors = 0;

  gol_gen_controller #(.ROWS(16), .TICK_DIV(4), .ALG_LATENCY(1), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_pause(cmd_pause), .cmd_step(cmd_step),
    .cmd_clear(cmd_clear), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .wr_ready(wr_ready),
    .alg_board_in(alg_in), .alg_board_out(alg_out), .board(board), .generation(generation),
    .running(running), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] life(input logic [255:0] b);
    logic [255:0] n;
    n = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
              cnt += int'(b[(r + dr) * 16 + c + dc]);
        n[r * 16 + c] = cnt == 3 || (cnt == 2 && b[r * 16 + c]);
      end
    return n;
  endfunction

  always @(posedge clk) alg_out <= life(alg_in);

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] row, input logic [15:0] data);
    wr_en = 1; wr_row = row; wr_data = data;
    cyc();
    wr_en = 0;
  endtask

  initial begin
    cyc(3);
    reset = 1;
    chk("rst_board", board, 0);
    chk("rst_gen", generation, 0);
    chk("rst_running", running, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_halted", halted, 0);
    // blinker: row write applied together with single step
    wr_en = 1; wr_row = 7; wr_data = 16'h0070; cmd_step = 1;
    cyc();
    wr_en = 0; cmd_step = 0;
    exp_b = '0; exp_b[116] = 1; exp_b[117] = 1; exp_b[118] = 1;
    chk("step_written", board, exp_b);
    chk("step_busy", busy, 1);
    chk("step_wr_ready", wr_ready, 0);
    cyc();
    chk("step_hold", board, exp_b);
    cyc();
    exp_b = '0; exp_b[101] = 1; exp_b[117] = 1; exp_b[133] = 1;
    chk("step_board", board, exp_b);
    chk("step_gen", generation, 1);
    chk("step_idle", wr_ready, 1);
    // clear wins over a simultaneous row write
    wr_en = 1; wr_row = 3; wr_data = 16'hFFFF; cmd_clear = 1;
    cyc();
    wr_en = 0; cmd_clear = 0;
    chk("clr_wr_board", board, 0);
    chk("clr_wr_gen", generation, 0);
    // glider run
    wr(0, 16'h0002); wr(1, 16'h0004); wr(2, 16'h0007);
    cmd_run = 1;
    cyc();
    cmd_run = 0;
    chk("run_running", running, 1);
    cyc(5);
    chk("run_commit_state", busy, 1);
    chk("run_gen0", generation, 0);
    cyc();
    chk("run_gen1", generation, 1);
    chk("run_wait_busy", busy, 0);
    cyc(18);
    exp_b = '0; exp_b[16 +: 16] = 16'h0004; exp_b[32 +: 16] = 16'h0008; exp_b[48 +: 16] = 16'h000E;
    chk("run_gen4", generation, 4);
    chk("glider_shift", board, exp_b);
    wr_en = 1; wr_row = 3; wr_data = 16'hFFFF;
    chk("wait_wr_ready", wr_ready, 0);
    cyc();
    wr_en = 0;
    chk("wait_wr_dropped", board, exp_b);
    cyc(3);
    chk("eval_reached", busy, 1);
    cmd_pause = 1;
    cyc();
    cmd_pause = 0;
    chk("pause_no_commit_yet", generation, 4);
    cyc();
    exp_b = '0; exp_b[32 +: 16] = 16'h000A; exp_b[48 +: 16] = 16'h000C; exp_b[64 +: 16] = 16'h0004;
    chk("pause_gen", generation, 5);
    chk("pause_running", running, 0);
    chk("pause_idle", wr_ready, 1);
    chk("pause_board", board, exp_b);
    cyc(8);
    chk("pause_stays", generation, 5);
    // clear during EVAL aborts
    cmd_step = 1;
    cyc();
    cmd_step = 0;
    chk("clr_eval_busy", busy, 1);
    cmd_clear = 1;
    cyc();
    cmd_clear = 0;
    chk("clr_eval_board", board, 0);
    chk("clr_eval_gen", generation, 0);
    chk("clr_eval_idle", wr_ready, 1);
    cyc(3);
    chk("clr_no_commit", generation, 0);
    // pause during WAIT_TICK
    cmd_run = 1;
    cyc();
    cmd_run = 0;
    cyc();
    cmd_pause = 1;
    cyc();
    cmd_pause = 0;
    chk("wt_pause_running", running, 0);
    chk("wt_pause_idle", wr_ready, 1);
    cyc(8);
    chk("wt_pause_gen", generation, 0);
    // still life block
    wr(0, 16'h0003); wr(1, 16'h0003);
    exp_b = '0; exp_b[0] = 1; exp_b[1] = 1; exp_b[16] = 1; exp_b[17] = 1;
    cmd_run = 1;
    cyc();
    cmd_run = 0;
    cyc(6);
    chk("block_gen1", generation, 1);
    chk("block_board", board, exp_b);
`ifdef GOL_STABLE_HALT_EN
    chk("block_halted", halted, 1);
    chk("block_running", running, 0);
    cyc(12);
    chk("block_stays", generation, 1);
    wr(5, 16'h0000);
    chk("halt_cleared", halted, 0);
`else
    chk("block_halted", halted, 0);
    chk("block_running", running, 1);
    cyc(12);
    chk("block_gen3", generation, 3);
`endif
    cmd_clear = 1;
    cyc();
    cmd_clear = 0;
    // reset mid-EVAL discards the generation
    wr(4, 16'h0707);
    cmd_step = 1;
    cyc();
    cmd_step = 0;
    reset = 0;
    cyc();
    reset = 1;
    chk("rst_eval_board", board, 0);
    chk("rst_eval_gen", generation, 0);
    chk("rst_eval_busy", busy, 0);
    cyc(3);
    chk("rst_eval_after", generation, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
